// File: rtl/alu_divider.sv
// Sequential signed divider for the calculator datapath: restoring shift-subtract,
// one quotient bit per clock, truncating toward zero like Verilog / and %.
module alu_divider #(
  parameter int unsigned BITS = 21,
  parameter int unsigned OPW  = 11
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [OPW-1:0]  regA,
  input  logic [OPW-1:0]  regB,
  input  logic            computestrobe,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] result,
  output logic [OPW-1:0]  remainder,
  output logic            ovf
);

  localparam int unsigned CW = $clog2(OPW + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;
  localparam logic [1:0] S_ZERO = 2'd3;

  logic [1:0]      state, state_next;
  logic [OPW-1:0]  dvd, dvd_next;     // dividend shifts out, quotient shifts in
  logic [OPW-1:0]  dsr, dsr_next;     // divisor magnitude
  logic [OPW-1:0]  part, part_next;   // partial remainder, always < |B|
  logic [CW-1:0]   cnt, cnt_next;
  logic            neg_q, neg_q_next;
  logic            neg_r, neg_r_next;
  logic            busy_next, done_next, ovf_next;
  logic [BITS-1:0] result_next;
  logic [OPW-1:0]  remainder_next;

  logic [OPW:0]    trial;
  logic            qbit;
  logic [BITS-1:0] q_ext;

  // Next-state and datapath update
  always_comb begin
    state_next     = state;
    dvd_next       = dvd;
    dsr_next       = dsr;
    part_next      = part;
    cnt_next       = cnt;
    neg_q_next     = neg_q;
    neg_r_next     = neg_r;
    busy_next      = busy;
    done_next      = 1'b0;
    ovf_next       = ovf;
    result_next    = result;
    remainder_next = remainder;

    // Partial remainder is OPW+1 bits only during the trial, so |A|=1024 cannot overflow
    trial = {part, dvd[OPW-1]};
    qbit  = (trial >= {1'b0, dsr});
    q_ext = {{(BITS - OPW){1'b0}}, dvd};

    case (state)
      S_IDLE: begin
        if (computestrobe) begin
          dvd_next   = regA[OPW-1] ? (~regA + OPW'(1)) : regA;
          dsr_next   = regB[OPW-1] ? (~regB + OPW'(1)) : regB;
          part_next  = '0;
          cnt_next   = CW'(OPW);
          neg_q_next = regA[OPW-1] ^ regB[OPW-1];
          neg_r_next = regA[OPW-1];
          ovf_next   = 1'b0;
          busy_next  = 1'b1;
          state_next = (regB == '0) ? S_ZERO : S_DIV;
        end
      end
      S_DIV: begin
        part_next = qbit ? OPW'(trial - {1'b0, dsr}) : trial[OPW-1:0];
        dvd_next  = {dvd[OPW-2:0], qbit};
        cnt_next  = cnt - CW'(1);
        if (cnt == CW'(1)) state_next = S_SIGN;
      end
      S_SIGN: begin
        result_next    = neg_q ? (~q_ext + BITS'(1)) : q_ext;
        remainder_next = neg_r ? (~part + OPW'(1)) : part;
        done_next      = 1'b1;
        busy_next      = 1'b0;
        state_next     = S_IDLE;
      end
      default: begin
        result_next    = '0;
        remainder_next = '0;
        ovf_next       = 1'b1;
        done_next      = 1'b1;
        busy_next      = 1'b0;
        state_next     = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      dvd       <= '0;
      dsr       <= '0;
      part      <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      result    <= '0;
      remainder <= '0;
    end else begin
      state     <= state_next;
      dvd       <= dvd_next;
      dsr       <= dsr_next;
      part      <= part_next;
      cnt       <= cnt_next;
      neg_q     <= neg_q_next;
      neg_r     <= neg_r_next;
      busy      <= busy_next;
      done      <= done_next;
      ovf       <= ovf_next;
      result    <= result_next;
      remainder <= remainder_next;
    end
  end

endmodule
